// File: rtl/pulse_sched_pkg.sv
// Shared state encoding and default widths for the radar pulse-repetition scheduler.
package pulse_sched_pkg;

    localparam int PRIW_DEF = 32;
    localparam int TXW_DEF  = 14;
    localparam int RXW_DEF  = 16;
    localparam int PAW_DEF  = 8;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        TX,
        LAG,
        WAIT
    } state_t;

endpackage

// File: rtl/pulse_sched_rx.sv
// ADC capture window: a delay/length counter restarted by every trigger, independent of the TX sequencer.
module rx_window #(
    parameter int RXW = 16
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           start,
    input  logic [RXW-1:0] rx_delay,
    input  logic [RXW-1:0] rxsmps,
    output logic           rx_valid,
    output logic           rx_first
);

    logic [RXW:0]   cnt, cnt_nx, stop_nx;
    logic [RXW-1:0] dly, dly_nx, len, len_nx;
    logic           run, run_nx;
    logic           valid_nx, first_nx;

    // The counter stops once it reaches delay+length, so a zero-length window never opens.
    always_comb begin
        run_nx = run;
        cnt_nx = cnt;
        dly_nx = dly;
        len_nx = len;
        if (start) begin
            run_nx = 1'b1;
            cnt_nx = '0;
            dly_nx = rx_delay;
            len_nx = rxsmps;
        end else if (run) begin
            cnt_nx = cnt + 1'b1;
        end
        stop_nx = {1'b0, dly_nx} + {1'b0, len_nx};
        if (cnt_nx >= stop_nx) begin
            run_nx = 1'b0;
        end
        valid_nx = run_nx && (cnt_nx >= {1'b0, dly_nx});
        first_nx = valid_nx && (cnt_nx == {1'b0, dly_nx});
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            run      <= 1'b0;
            cnt      <= '0;
            dly      <= '0;
            len      <= '0;
            rx_valid <= 1'b0;
            rx_first <= 1'b0;
        end else begin
            run      <= run_nx;
            cnt      <= cnt_nx;
            dly      <= dly_nx;
            len      <= len_nx;
            rx_valid <= valid_nx;
            rx_first <= first_nx;
        end
    end

endmodule

// File: rtl/pulse_sched.sv
// Per-PRI trigger generator sequencing PA guard, DAC playback address and the RX capture window.
module pulse_sched
    import pulse_sched_pkg::*;
#(
    parameter int PRIW = PRIW_DEF,
    parameter int TXW  = TXW_DEF,
    parameter int RXW  = RXW_DEF,
    parameter int PAW  = PAW_DEF
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            enable,
    input  logic [PRIW-1:0] pri,
    input  logic [TXW-1:0]  txsmps,
    input  logic [PAW-1:0]  pa_lead,
    input  logic [PAW-1:0]  pa_lag,
    input  logic [RXW-1:0]  rx_delay,
    input  logic [RXW-1:0]  rxsmps,
    output logic            trig,
    output logic            pa_en,
    output logic            tx_active,
    output logic [TXW-1:0]  tx_addr,
    output logic            rx_valid,
    output logic            rx_first,
    output logic            busy,
    output logic            cfg_err,
    output logic [31:0]     pulse_cnt
);

    localparam int SW = PRIW + 1;

    state_t          state, state_nx;
    logic [PRIW-1:0] k, k_nx;
    logic [PRIW-1:0] sh_pri, sh_pri_nx;
    logic [TXW-1:0]  sh_tx, sh_tx_nx;
    logic [PAW-1:0]  sh_lead, sh_lead_nx, sh_lag, sh_lag_nx;
    logic [SW-1:0]   pa_sum_in, rx_sum_in, tx_end, pa_end;
    logic            cfg_ok, last, want_trig;
    logic            trig_nx, err_nx, pa_en_nx, tx_active_nx, busy_nx;
    logic [TXW-1:0]  tx_addr_nx;

    // Sums are one bit wider than the PRI so oversized guards cannot wrap into a valid value.
    always_comb begin
        pa_sum_in = SW'(pa_lead) + SW'(txsmps) + SW'(pa_lag);
        rx_sum_in = SW'(rx_delay) + SW'(rxsmps);
        cfg_ok    = (pri >= PRIW'(2)) && (txsmps != '0) &&
                    (pa_sum_in <= SW'(pri)) && (rx_sum_in <= SW'(pri));
        tx_end    = SW'(sh_lead) + SW'(sh_tx);
        pa_end    = tx_end + SW'(sh_lag);
    end

    always_comb begin
        state_nx   = state;
        k_nx       = k;
        sh_pri_nx  = sh_pri;
        sh_tx_nx   = sh_tx;
        sh_lead_nx = sh_lead;
        sh_lag_nx  = sh_lag;
        trig_nx    = 1'b0;
        err_nx     = cfg_err;
        last       = (state != IDLE) && (k == sh_pri - 1'b1);
        want_trig  = enable && ((state == IDLE) || last);

        if (want_trig && cfg_ok) begin
            trig_nx    = 1'b1;
            err_nx     = 1'b0;
            k_nx       = '0;
            sh_pri_nx  = pri;
            sh_tx_nx   = txsmps;
            sh_lead_nx = pa_lead;
            sh_lag_nx  = pa_lag;
            state_nx   = (pa_lead == '0) ? TX : LEAD;
        end else if (want_trig || last) begin
            err_nx   = want_trig ? 1'b1 : cfg_err;
            k_nx     = '0;
            state_nx = IDLE;
        end else if (state != IDLE) begin
            k_nx = k + 1'b1;
            case (state)
                LEAD: if (SW'(k_nx) == SW'(sh_lead)) state_nx = TX;
                TX:   if (SW'(k_nx) == tx_end) state_nx = (sh_lag == '0) ? WAIT : LAG;
                LAG:  if (SW'(k_nx) == pa_end) state_nx = WAIT;
                default: ;
            endcase
        end

        pa_en_nx     = (state_nx == LEAD) || (state_nx == TX) || (state_nx == LAG);
        tx_active_nx = (state_nx == TX);
        tx_addr_nx   = tx_active_nx ? TXW'(k_nx - PRIW'(sh_lead_nx)) : '0;
        busy_nx      = (state_nx != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            k         <= '0;
            sh_pri    <= '0;
            sh_tx     <= '0;
            sh_lead   <= '0;
            sh_lag    <= '0;
            trig      <= 1'b0;
            pa_en     <= 1'b0;
            tx_active <= 1'b0;
            tx_addr   <= '0;
            busy      <= 1'b0;
            cfg_err   <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            state     <= state_nx;
            k         <= k_nx;
            sh_pri    <= sh_pri_nx;
            sh_tx     <= sh_tx_nx;
            sh_lead   <= sh_lead_nx;
            sh_lag    <= sh_lag_nx;
            trig      <= trig_nx;
            pa_en     <= pa_en_nx;
            tx_active <= tx_active_nx;
            tx_addr   <= tx_addr_nx;
            busy      <= busy_nx;
            cfg_err   <= err_nx;
            if (trig_nx) begin
                pulse_cnt <= pulse_cnt + 1'b1;
            end
        end
    end

    rx_window #(
        .RXW(RXW)
    ) u_rx_window (
        .clk      (clk),
        .rstn     (rstn),
        .start    (trig_nx),
        .rx_delay (rx_delay),
        .rxsmps   (rxsmps),
        .rx_valid (rx_valid),
        .rx_first (rx_first)
    );

endmodule

// File: tb/tb_pulse_sched.sv
// Directed bench for pulse_sched: per-cycle expectations derived from the programmed PRI windows.
module tb_pulse_sched;

    logic        clk;
    logic        rstn;
    logic        enable;
    logic [31:0] pri;
    logic [13:0] txsmps;
    logic [7:0]  pa_lead;
    logic [7:0]  pa_lag;
    logic [15:0] rx_delay;
    logic [15:0] rxsmps;
    logic        trig, pa_en, tx_active, rx_valid, rx_first, busy, cfg_err;
    logic [13:0] tx_addr;
    logic [31:0] pulse_cnt;

    int assertCount = 0;
    int failCount   = 0;
    int expCnt      = 0;
    int cfgPri, cfgLead, cfgTx, cfgLag, cfgRxd, cfgRxs;
    int chgAt       = -1;
    int chgTx       = 0;

    pulse_sched dut (
        .clk       (clk),
        .rstn      (rstn),
        .enable    (enable),
        .pri       (pri),
        .txsmps    (txsmps),
        .pa_lead   (pa_lead),
        .pa_lag    (pa_lag),
        .rx_delay  (rx_delay),
        .rxsmps    (rxsmps),
        .trig      (trig),
        .pa_en     (pa_en),
        .tx_active (tx_active),
        .tx_addr   (tx_addr),
        .rx_valid  (rx_valid),
        .rx_first  (rx_first),
        .busy      (busy),
        .cfg_err   (cfg_err),
        .pulse_cnt (pulse_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d required %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int p, input int l, input int t, input int g, input int d, input int s);
        cfgPri   = p;
        cfgLead  = l;
        cfgTx    = t;
        cfgLag   = g;
        cfgRxd   = d;
        cfgRxs   = s;
        pri      = 32'(p);
        pa_lead  = 8'(l);
        txsmps   = 14'(t);
        pa_lag   = 8'(g);
        rx_delay = 16'(d);
        rxsmps   = 16'(s);
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, " trig"}, 32'(trig), 0);
        checkOutput({tag, " pa_en"}, 32'(pa_en), 0);
        checkOutput({tag, " tx_active"}, 32'(tx_active), 0);
        checkOutput({tag, " tx_addr"}, 32'(tx_addr), 0);
        checkOutput({tag, " rx_valid"}, 32'(rx_valid), 0);
        checkOutput({tag, " rx_first"}, 32'(rx_first), 0);
        checkOutput({tag, " busy"}, 32'(busy), 0);
        checkOutput({tag, " cfg_err"}, 32'(cfg_err), 0);
        checkOutput({tag, " pulse_cnt"}, pulse_cnt, 0);
    endtask

    task automatic doReset();
        enable = 1'b0;
        rstn   = 1'b0;
        @(negedge clk);
        checkZero("reset");
        rstn   = 1'b1;
        expCnt = 0;
    endtask

    // Called at the negedge of k=0; enable drops after the checks of cycle dropAt.
    task automatic runCycles(input int ncyc, input int dropAt);
        bit alive = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            int p  = i / cfgPri;
            int km = i % cfgPri;
            int txP;
            bit pe, ta, rv, rf;
            int addr;
            if (dropAt >= 0 && dropAt < p * cfgPri) alive = 1'b0;
            txP  = (chgAt >= 0 && p * cfgPri > chgAt) ? chgTx : cfgTx;
            if (alive && km == 0) expCnt++;
            pe   = alive && (km < cfgLead + txP + cfgLag);
            ta   = alive && (km >= cfgLead) && (km < cfgLead + txP);
            addr = ta ? km - cfgLead : 0;
            rv   = alive && (km >= cfgRxd) && (km < cfgRxd + cfgRxs);
            rf   = alive && (cfgRxs > 0) && (km == cfgRxd);
            checkOutput($sformatf("c%0d trig", i), 32'(trig), 32'(alive && km == 0));
            checkOutput($sformatf("c%0d pa_en", i), 32'(pa_en), 32'(pe));
            checkOutput($sformatf("c%0d tx_active", i), 32'(tx_active), 32'(ta));
            checkOutput($sformatf("c%0d tx_addr", i), 32'(tx_addr), 32'(addr));
            checkOutput($sformatf("c%0d rx_valid", i), 32'(rx_valid), 32'(rv));
            checkOutput($sformatf("c%0d rx_first", i), 32'(rx_first), 32'(rf));
            checkOutput($sformatf("c%0d busy", i), 32'(busy), 32'(alive));
            checkOutput($sformatf("c%0d cfg_err", i), 32'(cfg_err), 0);
            checkOutput($sformatf("c%0d pulse_cnt", i), pulse_cnt, 32'(expCnt));
            if (i == dropAt) enable = 1'b0;
            if (i == chgAt) txsmps = 14'(chgTx);
            @(negedge clk);
        end
    endtask

    initial begin
        rstn   = 1'b0;
        enable = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        checkZero("init");
        rstn = 1'b1;

        // Nominal: three triggers at k=0, 100, 200.
        applyStimulus(100, 4, 10, 3, 20, 50);
        enable = 1'b1;
        @(negedge clk);
        runCycles(201, -1);
        doReset();

        // Invalid guards, then an RX window one cycle too long, then an exact-fit RX window.
        applyStimulus(10, 4, 10, 3, 0, 0);
        enable = 1'b1;
        @(negedge clk);
        checkOutput("inv trig", 32'(trig), 0);
        checkOutput("inv cfg_err", 32'(cfg_err), 1);
        checkOutput("inv busy", 32'(busy), 0);
        @(negedge clk);
        checkOutput("inv2 trig", 32'(trig), 0);
        checkOutput("inv2 cfg_err", 32'(cfg_err), 1);
        applyStimulus(70, 4, 10, 3, 20, 51);
        @(negedge clk);
        checkOutput("rxinv trig", 32'(trig), 0);
        checkOutput("rxinv busy", 32'(busy), 0);
        applyStimulus(70, 4, 10, 3, 20, 50);
        @(negedge clk);
        checkOutput("fix trig", 32'(trig), 1);
        checkOutput("fix cfg_err", 32'(cfg_err), 0);
        checkOutput("fix busy", 32'(busy), 1);
        checkOutput("fix pulse_cnt", pulse_cnt, 1);
        doReset();

        // Enable dropped at k=5: pulse and RX window complete, no second PRI.
        applyStimulus(100, 4, 10, 3, 20, 50);
        enable = 1'b1;
        @(negedge clk);
        runCycles(110, 5);
        doReset();

        // Zero guards with TX filling the whole PRI.
        applyStimulus(8, 0, 8, 0, 0, 0);
        enable = 1'b1;
        @(negedge clk);
        runCycles(40, -1);
        doReset();

        // txsmps written mid-PRI only affects the following PRI.
        applyStimulus(100, 4, 10, 3, 20, 50);
        chgAt  = 50;
        chgTx  = 20;
        enable = 1'b1;
        @(negedge clk);
        runCycles(130, -1);
        chgAt = -1;
        doReset();

        // Reset at k=7 clears everything; release with enable held retriggers.
        applyStimulus(100, 4, 10, 3, 20, 50);
        enable = 1'b1;
        @(negedge clk);
        runCycles(7, -1);
        rstn = 1'b0;
        @(negedge clk);
        checkZero("midrst");
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("rel trig", 32'(trig), 1);
        checkOutput("rel busy", 32'(busy), 1);
        checkOutput("rel pa_en", 32'(pa_en), 1);
        checkOutput("rel pulse_cnt", pulse_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/pulse_sched.md
Name: pulse_sched

Overview:
Radar pulse-repetition scheduler in the ref_clk (192 MHz) domain. Generates the per-PRI trigger and sequences three things within each PRI: PA-enable guard, DAC playback address (dac_0_addr of the RFSoC block design), and the ADC receive capture window. Config comes from the PS register bank. All values are latched at each trigger, so register writes take effect only on the next PRI.

Parameters:
PRIW, 32, PRI counter width
TXW, 14, DAC sample address/count width
RXW, 16, RX window length/delay width
PAW, 8, PA lead/lag width

Ports:
clk  in  1  ref_clk
rstn  in  1  synchronous active-low reset
enable  in  1  run request, level
pri  in  PRIW  PRI length in cycles
txsmps  in  TXW  DAC samples per pulse
pa_lead  in  PAW  PA-on cycles before first TX sample
pa_lag  in  PAW  PA-on cycles after last TX sample
rx_delay  in  RXW  trigger-to-RX-window offset
rxsmps  in  RXW  RX window length (0 = no window)
trig  out  1  one-cycle pulse at PRI start
pa_en  out  1  PA enable
tx_active  out  1  DAC playback valid
tx_addr  out  TXW  DAC sample address
rx_valid  out  1  ADC capture window
rx_first  out  1  first cycle of rx_valid
busy  out  1  sequencer not IDLE
cfg_err  out  1  sticky config error
pulse_cnt  out  32  triggers issued, wraps at 2^32

Behaviour:
- All outputs registered. While rstn=0 at any edge, all outputs go to 0 at that edge; state goes to IDLE and shadow config is cleared, including mid-PRI.
- k = cycle index within the PRI; k=0 is the trig cycle.
- Start: enable=1 sampled in IDLE at edge n gives trig=1 at cycle n+1 (k=0), provided the config is valid.
- Validity is checked with 33-bit sums: pri>=2, txsmps>=1, pa_lead+txsmps+pa_lag <= pri, rx_delay+rxsmps <= pri.
- Invalid config: no trig, cfg_err<=1, stay IDLE. cfg_err is cleared only by reset or by the next valid trigger.
- Shadow registers are latched at every trig. Inputs are ignored mid-PRI.
- pa_en=1 for k in [0, pa_lead+txsmps+pa_lag-1].
- tx_active=1 and tx_addr=k-pa_lead for k in [pa_lead, pa_lead+txsmps-1]; otherwise tx_addr=0.
- rx_valid=1 for k in [rx_delay, rx_delay+rxsmps-1]. rx_first=1 at k=rx_delay only when rxsmps>0.
- At k=pri-1 end of PRI:
  - enable=1: re-check config; if valid, the next cycle is k=0 with trig. If invalid, set cfg_err and go IDLE.
  - enable=0: go IDLE; busy=0 from the next cycle. No truncation of the current pulse.
- FSM states: IDLE, LEAD, TX, LAG, WAIT.
  - IDLE -> LEAD, or -> TX when pa_lead=0.
  - LEAD -> TX after pa_lead cycles.
  - TX -> LAG after txsmps cycles, or -> WAIT when pa_lag=0.
  - LAG -> WAIT after pa_lag cycles.
  - WAIT -> (LEAD|TX with trig) or IDLE at k=pri-1.
  - When the sum equals pri, LAG/TX leads directly into the next trig.
- The RX window runs from its own counter, independent of FSM state.
- pulse_cnt increments on each trig cycle and wraps 0xFFFFFFFF -> 0.
- busy=1 from trig through the last cycle of the PRI.

Decomposition:
- Package pulse_sched_pkg: state enum (IDLE, LEAD, TX, LAG, WAIT) and default widths.
- Sub-module rx_window: loadable delay/length counter producing rx_valid/rx_first. It is started by trig.

Test Plan:
- Nominal PRI: pri=100, pa_lead=4, txsmps=10, pa_lag=3, rx_delay=20, rxsmps=50.
  - Required: trig at k=0 and k=100; pa_en k0..16; tx_active k4..13 with tx_addr 0..9; rx_valid k20..69; rx_first at k20; pulse_cnt 1 then 2.
- Invalid config: pri=10, pa_lead=4, txsmps=10 -> no trig, cfg_err=1, busy=0. Fix pri=100 -> trig, cfg_err=0.
- Enable drop: enable deasserted at k=5 -> full pulse through k=16, RX window completes, no trig at k=100, busy=0 from k=100.
- Zero guards, tight fit: pa_lead=0, pa_lag=0, txsmps=8, pri=8, rxsmps=0 -> tx_active continuous with tx_addr 0..7 repeating, trig every 8 cycles, rx_valid never high.
- Mid-PRI config change: txsmps 10->20 at k=50 -> current PRI tx_active k4..13; next PRI k4..23.
- Reset mid-op: rstn=0 at k=7 -> next edge all outputs 0, pulse_cnt=0. After release with enable=1 -> trig one cycle later.
